// File: rtl/remote_pkg.sv
// Shared definitions for both ends of the remote command link:
// receive FSM states, default timing constants and response codes.
package remote_pkg;

   typedef enum logic {HIGH = 1'b0, LOW = 1'b1} rx_state_t;

   localparam int BYTE_TO_DEFAULT  = 1 << 20;
   localparam int BAUD_DIV_DEFAULT = 2604;

   localparam logic [7:0] RESP_ACK = 8'hA5;
   localparam logic [7:0] RESP_POS = 8'h5A;

endpackage

// File: rtl/UART.sv
// 8N1 UART transceiver with independent transmit and receive paths.
// BAUD_DIV is the number of clk cycles per serial bit.
module UART #(
   parameter int BAUD_DIV = 2604
) (
   input  logic       clk,
   input  logic       rst_n,
   input  logic       RX,
   output logic       TX,
   output logic       rx_rdy,
   output logic [7:0] rx_data,
   input  logic       clr_rx_rdy,
   input  logic       trmt,
   input  logic [7:0] tx_data,
   output logic       tx_done
);

   localparam int BW = $clog2(BAUD_DIV);

   logic          tx_busy;
   logic [BW-1:0] tx_baud;
   logic [3:0]    tx_bits;
   logic [9:0]    tx_shift;

   logic          rx_ff1, rx_ff2;
   logic          rx_busy;
   logic [BW-1:0] rx_baud;
   logic [3:0]    rx_bits;
   logic [9:0]    rx_shift;

   // Line idles on the all-ones shift register, so TX stays high outside a frame.
   assign TX      = tx_shift[0];
   assign rx_data = rx_shift[8:1];

   // Transmit: load {stop, data, start} and shift out LSB first.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         tx_busy  <= 1'b0;
         tx_baud  <= '0;
         tx_bits  <= 4'd0;
         tx_shift <= 10'h3FF;
         tx_done  <= 1'b0;
      end else if (trmt) begin
         tx_shift <= {1'b1, tx_data, 1'b0};
         tx_busy  <= 1'b1;
         tx_baud  <= '0;
         tx_bits  <= 4'd0;
         tx_done  <= 1'b0;
      end else if (tx_busy) begin
         if (tx_baud == BW'(BAUD_DIV - 1)) begin
            tx_baud  <= '0;
            tx_shift <= {1'b1, tx_shift[9:1]};
            tx_bits  <= tx_bits + 4'd1;
            if (tx_bits == 4'd9) begin
               tx_busy <= 1'b0;
               tx_done <= 1'b1;
            end
         end else begin
            tx_baud <= tx_baud + BW'(1);
         end
      end
   end

   // Receive: synchronise RX, then sample start, 8 data and stop bits at mid-bit.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         rx_ff1   <= 1'b1;
         rx_ff2   <= 1'b1;
         rx_busy  <= 1'b0;
         rx_baud  <= '0;
         rx_bits  <= 4'd0;
         rx_shift <= 10'h000;
         rx_rdy   <= 1'b0;
      end else begin
         rx_ff1 <= RX;
         rx_ff2 <= rx_ff1;
         if (clr_rx_rdy)
            rx_rdy <= 1'b0;
         if (!rx_busy) begin
            if (!rx_ff2) begin
               rx_busy <= 1'b1;
               rx_baud <= BW'(BAUD_DIV / 2);
               rx_bits <= 4'd0;
            end
         end else if (rx_baud == '0) begin
            rx_shift <= {rx_ff2, rx_shift[9:1]};
            rx_baud  <= BW'(BAUD_DIV - 1);
            rx_bits  <= rx_bits + 4'd1;
            if (rx_bits == 4'd9) begin
               rx_busy <= 1'b0;
               rx_rdy  <= 1'b1;
            end
         end else begin
            rx_baud <= rx_baud - BW'(1);
         end
      end
   end

endmodule

// File: rtl/uart_cmd_wrapper.sv
// Robot-side command link endpoint: reassembles two received bytes into a
// 16-bit command with a ready/clear handshake and forwards response bytes.
import remote_pkg::*;

module uart_cmd_wrapper #(
   parameter int BYTE_TO  = BYTE_TO_DEFAULT,
   parameter int BAUD_DIV = BAUD_DIV_DEFAULT
) (
   input  logic        clk,
   input  logic        rst_n,
   input  logic        RX,
   output logic        TX,
   output logic [15:0] cmd,
   output logic        cmd_rdy,
   input  logic        clr_cmd_rdy,
   input  logic        trmt,
   input  logic [7:0]  resp,
   output logic        tx_done
);

   localparam int TW = $clog2(BYTE_TO);

   logic          rx_rdy;
   logic [7:0]    rx_data;
   logic          clr_rx_rdy;
   logic          set_cmd_rdy;
   logic          msb_cap;
   logic [7:0]    cmd_hi, cmd_lo;
   logic [TW-1:0] tmo_cnt;
   rx_state_t     state;

   UART #(.BAUD_DIV(BAUD_DIV)) u_uart (
      .clk        (clk),
      .rst_n      (rst_n),
      .RX         (RX),
      .TX         (TX),
      .rx_rdy     (rx_rdy),
      .rx_data    (rx_data),
      .clr_rx_rdy (clr_rx_rdy),
      .trmt       (trmt),
      .tx_data    (resp),
      .tx_done    (tx_done)
   );

   // Every received byte is consumed in the cycle it is seen, in either state.
   assign clr_rx_rdy  = rx_rdy;
   assign msb_cap     = (state == HIGH) && rx_rdy;
   assign set_cmd_rdy = (state == LOW) && rx_rdy;
   assign cmd         = {cmd_hi, cmd_lo};

   // Byte-framing FSM with inter-byte timeout; cmd_rdy is an SR flop where set wins.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state   <= HIGH;
         cmd_hi  <= 8'h00;
         cmd_lo  <= 8'h00;
         cmd_rdy <= 1'b0;
         tmo_cnt <= '0;
      end else begin
         if (set_cmd_rdy)
            cmd_rdy <= 1'b1;
         else if (clr_cmd_rdy || msb_cap)
            cmd_rdy <= 1'b0;
         else
            cmd_rdy <= cmd_rdy;

         case (state)
            HIGH: begin
               if (rx_rdy) begin
                  cmd_hi  <= rx_data;
                  tmo_cnt <= '0;
                  state   <= LOW;
               end
            end
            LOW: begin
               if (rx_rdy) begin
                  cmd_lo <= rx_data;
                  state  <= HIGH;
               end else if (tmo_cnt == TW'(BYTE_TO - 1)) begin
                  // Drop the orphaned MSB so the next byte is treated as a new frame.
                  state <= HIGH;
               end else begin
                  tmo_cnt <= tmo_cnt + TW'(1);
               end
            end
            default: state <= HIGH;
         endcase
      end
   end

endmodule

// File: tb/tb_uart_cmd_wrapper.sv
// Directed, table-driven bench for uart_cmd_wrapper with a serial line model
// on RX and a frame decoder on TX.
module tb_uart_cmd_wrapper;
   import remote_pkg::*;

   localparam int BD  = 16;
   localparam int BTO = 1000;

   logic        clk = 1'b0;
   logic        rst_n = 1'b0;
   logic        RX = 1'b1;
   logic        TX;
   logic [15:0] cmd;
   logic        cmd_rdy;
   logic        clr_cmd_rdy = 1'b0;
   logic        trmt = 1'b0;
   logic [7:0]  resp = 8'h00;
   logic        tx_done;

   int checks = 0;
   int errors = 0;

   logic mon_en = 1'b0;
   logic mixed_seen = 1'b0;

   typedef struct {
      logic [15:0] frame;
      logic [7:0]  rsp;
      logic [15:0] exp_cmd;
      logic [7:0]  exp_tx;
   } vec_t;

   vec_t vecs [4];

   uart_cmd_wrapper #(.BYTE_TO(BTO), .BAUD_DIV(BD)) dut (
      .clk         (clk),
      .rst_n       (rst_n),
      .RX          (RX),
      .TX          (TX),
      .cmd         (cmd),
      .cmd_rdy     (cmd_rdy),
      .clr_cmd_rdy (clr_cmd_rdy),
      .trmt        (trmt),
      .resp        (resp),
      .tx_done     (tx_done)
   );

   always #5 clk = ~clk;

   always @(negedge clk)
      if (mon_en && cmd_rdy === 1'b1 && cmd === 16'h12CD)
         mixed_seen = 1'b1;

   task automatic chk(input string name, input logic [15:0] act, input logic [15:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s actual=%h required=%h", name, act, exp);
      end
   endtask

   task automatic send_byte(input logic [7:0] b);
      RX = 1'b0;
      repeat (BD) @(negedge clk);
      for (int i = 0; i < 8; i++) begin
         RX = b[i];
         repeat (BD) @(negedge clk);
      end
      RX = 1'b1;
      repeat (BD) @(negedge clk);
   endtask

   task automatic send_frame(input logic [15:0] f);
      send_byte(f[15:8]);
      send_byte(f[7:0]);
   endtask

   task automatic wait_rdy(output logic got);
      int n;
      n = 0;
      while (cmd_rdy !== 1'b1 && n < 400) begin
         @(negedge clk);
         n++;
      end
      got = (cmd_rdy === 1'b1);
   endtask

   task automatic send_resp(input logic [7:0] r);
      @(negedge clk);
      resp = r;
      trmt = 1'b1;
      @(negedge clk);
      trmt = 1'b0;
   endtask

   task automatic recv_tx(output logic [7:0] b, output logic ok);
      int n;
      ok = 1'b0;
      b = 8'h00;
      n = 0;
      while (TX !== 1'b0 && n < 400) begin
         @(negedge clk);
         n++;
      end
      if (TX === 1'b0) begin
         repeat (BD / 2) @(negedge clk);
         if (TX === 1'b0) begin
            for (int i = 0; i < 8; i++) begin
               repeat (BD) @(negedge clk);
               b[i] = TX;
            end
            repeat (BD) @(negedge clk);
            ok = (TX === 1'b1);
         end
      end
   endtask

   task automatic wait_tx_done(output logic got);
      int n;
      n = 0;
      while (tx_done !== 1'b1 && n < 60) begin
         @(negedge clk);
         n++;
      end
      got = (tx_done === 1'b1);
   endtask

   task automatic pulse_clr();
      clr_cmd_rdy = 1'b1;
      @(negedge clk);
      clr_cmd_rdy = 1'b0;
   endtask

   initial begin
      logic        got;
      logic        ok;
      logic        seen;
      logic [7:0]  b;
      logic [15:0] held;

      vecs[0] = '{16'h2C4B, RESP_ACK, 16'h2C4B, 8'hA5};
      vecs[1] = '{16'hC350, RESP_POS, 16'hC350, 8'h5A};
      vecs[2] = '{16'hFFFF, 8'h00,    16'hFFFF, 8'h00};
      vecs[3] = '{16'h8001, 8'hFF,    16'h8001, 8'hFF};

      repeat (3) @(negedge clk);
      chk("reset_cmd_rdy", {15'd0, cmd_rdy}, 16'd0);
      chk("reset_cmd", cmd, 16'h0000);
      chk("reset_tx", {15'd0, TX}, 16'd1);
      chk("reset_tx_done", {15'd0, tx_done}, 16'd0);
      rst_n = 1'b1;
      repeat (3) @(negedge clk);

      for (int v = 0; v < 4; v++) begin
         send_frame(vecs[v].frame);
         wait_rdy(got);
         chk("vec_cmd_rdy", {15'd0, got}, 16'd1);
         chk("vec_cmd", cmd, vecs[v].exp_cmd);
         pulse_clr();
         chk("vec_clr", {15'd0, cmd_rdy}, 16'd0);
         chk("vec_cmd_hold", cmd, vecs[v].exp_cmd);
         send_resp(vecs[v].rsp);
         recv_tx(b, ok);
         chk("vec_tx_frame", {15'd0, ok}, 16'd1);
         chk("vec_tx_byte", {8'h00, b}, {8'h00, vecs[v].exp_tx});
         wait_tx_done(got);
         chk("vec_tx_done", {15'd0, got}, 16'd1);
      end

      // Back-to-back frames without acknowledge: ready must drop on the new MSB.
      mon_en = 1'b1;
      send_frame(16'h1234);
      wait_rdy(got);
      chk("b2b_first_rdy", {15'd0, got}, 16'd1);
      chk("b2b_first_cmd", cmd, 16'h1234);
      send_byte(8'hAB);
      chk("b2b_msb_drop", {15'd0, cmd_rdy}, 16'd0);
      chk("b2b_msb_cmd", cmd, 16'hAB34);
      send_byte(8'hCD);
      wait_rdy(got);
      chk("b2b_second_rdy", {15'd0, got}, 16'd1);
      chk("b2b_second_cmd", cmd, 16'hABCD);
      mon_en = 1'b0;
      chk("b2b_no_mixed", {15'd0, mixed_seen}, 16'd0);
      pulse_clr();

      // Orphan MSB followed by a long gap must not pair with the next byte.
      send_byte(8'h55);
      repeat (BTO + 100) @(negedge clk);
      chk("tmo_idle_rdy", {15'd0, cmd_rdy}, 16'd0);
      send_byte(8'h0F);
      chk("tmo_no_ghost", {15'd0, cmd_rdy}, 16'd0);
      send_byte(8'h0F);
      wait_rdy(got);
      chk("tmo_rdy", {15'd0, got}, 16'd1);
      chk("tmo_cmd", cmd, 16'h0F0F);
      pulse_clr();

      // Receive and transmit running at the same time.
      fork
         send_frame(16'h3C96);
         begin
            send_resp(RESP_POS);
            recv_tx(b, ok);
         end
      join
      wait_rdy(got);
      chk("conc_rdy", {15'd0, got}, 16'd1);
      chk("conc_cmd", cmd, 16'h3C96);
      chk("conc_tx_frame", {15'd0, ok}, 16'd1);
      chk("conc_tx_byte", {8'h00, b}, 16'h005A);
      wait_tx_done(got);
      chk("conc_tx_done", {15'd0, got}, 16'd1);
      pulse_clr();

      // Acknowledge held through the LSB: set must win for exactly one cycle.
      clr_cmd_rdy = 1'b1;
      seen = 1'b0;
      held = 16'h0000;
      fork
         send_frame(16'h4E71);
         begin
            for (int i = 0; i < 400; i++) begin
               @(negedge clk);
               if (cmd_rdy === 1'b1 && !seen) begin
                  seen = 1'b1;
                  held = cmd;
               end
            end
         end
      join
      chk("coll_set_wins", {15'd0, seen}, 16'd1);
      chk("coll_cmd", held, 16'h4E71);
      chk("coll_cleared_after", {15'd0, cmd_rdy}, 16'd0);
      clr_cmd_rdy = 1'b0;

      // Reset after an MSB and during a transmission.
      fork
         send_byte(8'h77);
         begin
            repeat (100) @(negedge clk);
            send_resp(RESP_ACK);
         end
      join
      rst_n = 1'b0;
      repeat (2) @(negedge clk);
      chk("rst_mid_cmd_rdy", {15'd0, cmd_rdy}, 16'd0);
      chk("rst_mid_cmd", cmd, 16'h0000);
      chk("rst_mid_tx", {15'd0, TX}, 16'd1);
      chk("rst_mid_tx_done", {15'd0, tx_done}, 16'd0);
      rst_n = 1'b1;
      repeat (3) @(negedge clk);
      send_frame(16'h8001);
      wait_rdy(got);
      chk("rst_after_rdy", {15'd0, got}, 16'd1);
      chk("rst_after_cmd", cmd, 16'h8001);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule

// File: doc/uart_cmd_wrapper.md
# uart_cmd_wrapper

Robot-side endpoint of the remote command link. It receives the two-byte command stream (MSB first, then LSB) over the serial line and reassembles it into a 16-bit command with a ready/clear handshake. It also forwards 8-bit response bytes (e.g. 0xA5 ack, 0x5A positive) back to the remote. It sits between the serial pins and the command-processing FSM, and wraps the existing `UART` transceiver.

## Interface
Parameters:
- `BYTE_TO`, 2^20: inter-byte timeout in clk cycles. If the LSB has not arrived this many cycles after the MSB, the partial command is dropped.

Ports:
- `clk` in 1: system clock; the only clock.
- `rst_n` in 1: asynchronous, active-low reset.
- `RX` in 1: serial input from the remote.
- `TX` out 1: serial output to the remote.
- `cmd` out 16: last completely received command, {MSB, LSB}.
- `cmd_rdy` out 1: new command available; held high until cleared.
- `clr_cmd_rdy` in 1: consumer acknowledge; clears `cmd_rdy`.
- `trmt` in 1: one-cycle pulse that starts transmission of `resp`.
- `resp` in 8: response byte to send; sampled on the `trmt` cycle.
- `tx_done` out 1: passthrough from `UART`; high once the response byte has fully shifted out.

## Operation
- Internal `UART` instance: outputs `rx_rdy`/`rx_data`; input `clr_rx_rdy` is driven by this block.
- The FSM has two states. Reset state is `HIGH`.
- `HIGH`:
  - On `rx_rdy`: load `cmd_hi <= rx_data`, pulse `clr_rx_rdy`, clear the timeout counter, go to `LOW`.
  - Otherwise stay in `HIGH`.
- `LOW`:
  - On `rx_rdy`: load `cmd_lo <= rx_data`, pulse `clr_rx_rdy`, pulse `set_cmd_rdy`, go to `HIGH`.
  - Otherwise, if the timeout counter reaches `BYTE_TO-1`, go to `HIGH` without touching `cmd_lo` or `cmd_rdy`. This resynchronises byte framing.
  - Otherwise increment the counter.
- `cmd = {cmd_hi, cmd_lo}`. Both halves are registered, so `cmd` is stable while `cmd_rdy` is high, except as noted below.
- `cmd_rdy` is an SR flop:
  - Cleared by `clr_cmd_rdy`, or by MSB capture (start of a new frame).
  - Set by `set_cmd_rdy`.
  - Set has priority over clear when they occur in the same cycle.
- Overrun: a new frame overwrites `cmd_hi` on its MSB. `cmd_rdy` drops at that point, so the consumer never sees a mixed command flagged ready.
- Response path: `trmt` and `resp` are wired straight to `UART` `trmt`/`tx_data`. The TX and RX paths are fully independent and may be active at the same time.
- `trmt` while a byte is still transmitting: unsupported. The consumer must wait for `tx_done`.

## Timing
- Reset values: `cmd_rdy=0`, `cmd=16'h0000`, `TX=1` (idle), `tx_done=0`, state=`HIGH`, timeout counter=0.
- `cmd_rdy` rises 1 clk after the `rx_rdy` for the LSB is seen. `cmd` is valid in that same cycle.
- `clr_rx_rdy` is a single-cycle pulse, issued in the same cycle `rx_rdy` is observed. `rx_rdy` therefore falls 1 clk later.
- `clr_cmd_rdy` drops `cmd_rdy` on the next edge.
- Reset mid-frame: the partial MSB is lost and the FSM returns to `HIGH`. A reset during TX aborts the byte and leaves `TX` high.
- Timeout is measured from MSB capture. An LSB arriving exactly on the timeout cycle is accepted, because `rx_rdy` has priority over the timeout.

## Structure
- Shared package `remote_pkg`:
  - `typedef enum logic {HIGH, LOW} rx_state_t`
  - default `BYTE_TO`
  - response constants `RESP_ACK=8'hA5` and `RESP_POS=8'h5A`. The remote end uses the same constants.
- Sub-modules: reuse the existing `UART`; no new sub-module.
- Timeout counter width = `$clog2(BYTE_TO)`.

## Test plan
- Remote sends 16'h2C4B: `cmd_rdy` rises with `cmd=16'h2C4B`. Pulse `clr_cmd_rdy`: `cmd_rdy=0` next clk, `cmd` unchanged.
- Back-to-back 16'h1234 then 16'hABCD without any `clr_cmd_rdy`:
  - `cmd_rdy` falls on the 0xAB capture, then rises with 16'hABCD.
  - `cmd` is never {12,CD} while `cmd_rdy=1`.
- MSB 0x55, then idle for more than `BYTE_TO` (set `BYTE_TO=1000` in the bench), then frame 16'h0F0F: result is `cmd=16'h0F0F` and no ghost command.
- `resp=8'hA5` with a `trmt` pulse: `TX` frame decodes to 0xA5 and `tx_done` rises. Repeat concurrently with an incoming command: both complete correctly.
- Assert `clr_cmd_rdy` in the same cycle `set_cmd_rdy` fires: `cmd_rdy=1`.
- Assert `rst_n` low after the MSB only: `cmd_rdy=0` and `cmd=0`. Next full frame 16'h8001 decodes correctly.
